// File: rtl/xor_parity_pkg.sv
// ----------------------------------------------------------------------------
// xor_parity_pkg
// Shared types and constants for the serial frame parity accumulator.
//   state_t          : FSM states of xor_frame_parity (IDLE, ACCUM, HOLD)
//   DEFAULT_MAX_LEN  : default maximum number of bits in one frame
// ----------------------------------------------------------------------------
package xor_parity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for the first bit of a frame
        ACCUM = 2'd1,   // frame open, folding bits into the parity
        HOLD  = 2'd2    // frame closed, result presented downstream
    } state_t;

    localparam int DEFAULT_MAX_LEN = 16;

endpackage : xor_parity_pkg

// File: rtl/xor_frame_parity.sv
// ----------------------------------------------------------------------------
// xor_frame_parity
// Accumulates a serial bit stream into frames and reports, per frame, the XOR
// of all accepted bits, the number of bits and whether the frame was cut off
// at MAX_LEN without an in_last marker.
//
// Parameters
//   MAX_LEN       maximum bits per frame (2..255)
// Ports
//   clk           clock, all state changes on the rising edge
//   reset         synchronous, active-high reset
//   in_valid      upstream offers in_bit / in_last this cycle
//   in_bit        serial data bit
//   in_last       offered bit closes the frame
//   in_ready      block accepts a bit this cycle (0 only while holding a result)
//   out_valid     a frame result is presented
//   out_ready     downstream takes the presented result
//   out_parity    XOR of all bits of the frame
//   out_count     number of bits in the frame
//   out_too_long  frame was truncated at MAX_LEN
// ----------------------------------------------------------------------------
module xor_frame_parity
    import xor_parity_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic                             in_bit,
    input  logic                             in_last,
    output logic                             in_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_parity,
    output logic [$clog2(MAX_LEN+1)-1:0]     out_count,
    output logic                             out_too_long
);

    localparam int            CW        = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_LEN);

    state_t          r_state;
    logic            r_parity;
    logic [CW-1:0]   r_count;
    logic            r_too_long;
    logic            r_out_valid;

    state_t          w_next_state;
    logic            w_next_parity;
    logic [CW-1:0]   w_next_count;
    logic            w_next_too_long;
    logic            w_in_ready;
    logic            w_accept;
    logic [CW-1:0]   w_count_inc;

    // Ready depends on the state register only, so there is no combinational
    // path from any input to in_ready.
    assign w_in_ready  = (r_state != HOLD);
    assign w_accept    = in_valid && w_in_ready;
    assign w_count_inc = r_count + CW'(1);

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_next_state    = r_state;
        w_next_parity   = r_parity;
        w_next_count    = r_count;
        w_next_too_long = r_too_long;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_parity = in_bit;
                    w_next_count  = CW'(1);
                    w_next_state  = in_last ? HOLD : ACCUM;
                end
            end

            ACCUM: begin
                if (w_accept) begin
                    w_next_parity = r_parity ^ in_bit;
                    w_next_count  = w_count_inc;
                    if (in_last || (w_count_inc == MAX_COUNT)) begin
                        w_next_state = HOLD;
                    end
                    // Truncation is flagged only when the length limit, not
                    // the in_last marker, closes the frame.
                    w_next_too_long = !in_last && (w_count_inc == MAX_COUNT);
                end
            end

            HOLD: begin
                if (out_ready) begin
                    w_next_state    = IDLE;
                    w_next_parity   = 1'b0;
                    w_next_count    = '0;
                    w_next_too_long = 1'b0;
                end
            end

            default: begin
                w_next_state    = IDLE;
                w_next_parity   = 1'b0;
                w_next_count    = '0;
                w_next_too_long = 1'b0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_parity    <= 1'b0;
            r_count     <= '0;
            r_too_long  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_parity    <= w_next_parity;
            r_count     <= w_next_count;
            r_too_long  <= w_next_too_long;
            // Registered copy of "next state is HOLD" so out_valid comes
            // straight from a flop and rises one cycle after the closing bit.
            r_out_valid <= (w_next_state == HOLD);
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_out_valid;
    assign out_parity   = r_parity;
    assign out_count    = r_count;
    assign out_too_long = r_too_long;

endmodule : xor_frame_parity
